// File: rtl/fpadd_share_ctrl.sv
// Round-robin scheduler that time-shares one combinational single-precision adder between NUM_REQ requesters.
// Optional exception flags on the response (rsp_nan, rsp_inf) are built when FPADD_SHARE_EXC_FLAGS_EN is defined.

module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] s
);
   logic [31:0] x, y, rnd;
   logic [7:0]  ex, ey, d;
   logic [26:0] mx, my, sh;
   logic [27:0] sum;
   logic [8:0]  e;
   logic        up, a_nan, b_nan, a_inf, b_inf;

   always_comb begin
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      x  = (a[30:0] >= b[30:0]) ? a : b;
      y  = (a[30:0] >= b[30:0]) ? b : a;
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
      my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
      d  = ex - ey;
      // Bits shifted out of the smaller operand collapse into a sticky LSB
      if (d > 8'd26)
         sh = {26'd0, |my};
      else
         sh = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
      if (x[31] == y[31])
         sum = {1'b0, mx} + {1'b0, sh};
      else
         sum = {1'b0, mx} - {1'b0, sh};
      e = {1'b0, ex};
      if (sum[27]) begin
         sum = {1'b0, sum[27:2], sum[1] | sum[0]};
         e   = e + 9'd1;
      end
      for (int i = 0; i < 26; i++) begin
         if (!sum[26] && (e > 9'd1)) begin
            sum = sum << 1;
            e   = e - 9'd1;
         end
      end
      if (!sum[26])
         e = 9'd0;
      // Round to nearest even; a mantissa carry ripples into the exponent field
      up  = sum[2] & (sum[1] | sum[0] | sum[3]);
      rnd = {e, sum[25:3]} + {31'd0, up};
      if (a_nan)
         s = a | 32'h0040_0000;
      else if (b_nan)
         s = b | 32'h0040_0000;
      else if (a_inf && b_inf && (a[31] != b[31]))
         s = 32'h7FC0_0000;
      else if (a_inf)
         s = a;
      else if (b_inf)
         s = b;
      else if (sum == 28'd0)
         s = (x[31] == y[31]) ? {x[31], 31'd0} : 32'd0;
      else if (rnd[31:23] >= 9'd255)
         s = {x[31], 8'hFF, 23'd0};
      else
         s = {x[31], rnd[30:0]};
   end
endmodule

module fpadd_share_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [32*NUM_REQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_sum,
`ifdef FPADD_SHARE_EXC_FLAGS_EN
   output logic                    rsp_nan,
   output logic                    rsp_inf,
`endif
   output logic                    busy
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr, op_id, grant;
   logic [31:0]     op_a, op_b, sum_w;
   logic            found;

   adder u_adder (.a(op_a), .b(op_b), .s(sum_w));

   // Search starts just past the last winner so the most recent grant has lowest priority
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            found = 1'b1;
            grant = idx[ID_W-1:0];
         end
      end
      req_ready = '0;
      if ((state == IDLE) && found && !reset)
         req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= ID_W'(NUM_REQ - 1);
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef FPADD_SHARE_EXC_FLAGS_EN
         rsp_nan   <= 1'b0;
         rsp_inf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  op_a   <= req_a[32*grant +: 32];
                  op_b   <= req_b[32*grant +: 32];
                  op_id  <= grant;
                  rr_ptr <= grant;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               rsp_sum   <= sum_w;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
`ifdef FPADD_SHARE_EXC_FLAGS_EN
               rsp_nan   <= (sum_w[30:23] == 8'hFF) && (sum_w[22:0] != 23'd0);
               rsp_inf   <= (sum_w[30:23] == 8'hFF) && (sum_w[22:0] == 23'd0);
`endif
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Self-checking bench for fpadd_share_ctrl: directed scenarios plus random traffic against a transaction-level model.
// Build with FPADD_SHARE_EXC_FLAGS_EN defined to also check rsp_nan/rsp_inf.

module tb_fpadd_share_ctrl;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NUM_REQ-1:0]    vld = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] pa = '0, pb = '0;
   logic                  rdy = 1'b1;
   logic                  rsp_valid, busy;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_sum;
`ifdef FPADD_SHARE_EXC_FLAGS_EN
   logic                  rsp_nan, rsp_inf;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit hold_valid = 1'b0;

   // Transaction-level reference: who was served last, whether a job is outstanding, and its expected result
   bit          m_busy;
   int          m_age, m_last, m_id;
   logic [31:0] m_sum;
   bit          m_isnan;
   int          dut_grants[$];
   int          grant_cyc[$];

   fpadd_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(vld), .req_ready(req_ready),
      .req_a(pa), .req_b(pb),
      .rsp_valid(rsp_valid), .rsp_ready(rdy),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum),
`ifdef FPADD_SHARE_EXC_FLAGS_EN
      .rsp_nan(rsp_nan), .rsp_inf(rsp_inf),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic real to_real(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
      e = {3'd0, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   // IEEE sum via double-precision arithmetic, rounded back to single with round-to-nearest-even
   function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, output bit isnan);
      logic [63:0] r;
      int          ef;
      logic        up;
      logic [30:0] pk;
      bit a_nan, b_nan, a_inf, b_inf;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      isnan = a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]));
      if (isnan) return 32'h7FC0_0000;
      if (a_inf) return a;
      if (b_inf) return b;
      r = $realtobits(to_real(a) + to_real(b));
      if (r[62:0] == 63'd0) return {r[63], 31'd0};
      ef = int'(r[62:52]) - 896;
      up = r[28] && ((r[27:0] != 28'd0) || r[29]);
      pk = {ef[7:0], r[51:29]} + {30'd0, up};
      return {r[63], pk};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_busy = 1'b0;
      m_age  = 0;
      m_last = NUM_REQ - 1;
   endtask

   // One clock cycle: check the DUT against the model with the current inputs, then advance both
   task automatic applyStimulus();
      logic [NUM_REQ-1:0] exp_ready;
      int g;
      bit exp_rv;
      #1;
      g = -1;
      exp_ready = '0;
      if (!m_busy)
         for (int k = 1; k <= NUM_REQ; k++)
            if (g < 0 && vld[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_rv = m_busy && (m_age >= 1);
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
         if (m_isnan)
            checkOutput("rsp_sum_nan", 32'((rsp_sum[30:23] == 8'hFF) && (rsp_sum[22:0] != 0)), 32'd1);
         else
            checkOutput("rsp_sum", rsp_sum, m_sum);
`ifdef FPADD_SHARE_EXC_FLAGS_EN
         checkOutput("rsp_nan", 32'(rsp_nan), 32'(m_isnan));
         checkOutput("rsp_inf", 32'(rsp_inf), 32'(!m_isnan && (m_sum[30:0] == 31'h7F80_0000)));
`endif
      end
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) begin
            dut_grants.push_back(i);
            grant_cyc.push_back(cyc);
         end
      @(posedge clk);
      #1;
      cyc++;
      if (g >= 0) begin
         m_busy = 1'b1;
         m_age  = 0;
         m_last = g;
         m_id   = g;
         m_sum  = fp_ref(pa[32*g +: 32], pb[32*g +: 32], m_isnan);
         if (!hold_valid) vld[g] = 1'b0;
      end else if (m_busy) begin
         if (m_age >= 1 && rdy) m_busy = 1'b0;
         else m_age++;
      end
   endtask

   task automatic applyReset(input int n);
      reset = 1'b1;
      repeat (n) begin
         #1;
         checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      modelReset();
   endtask

   task automatic setOperands(input int id, input logic [31:0] a, input logic [31:0] b);
      pa[32*id +: 32] = a;
      pb[32*id +: 32] = b;
      vld[id] = 1'b1;
   endtask

   initial begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      $display("[TB] start");
      modelReset();
      @(posedge clk);
      #1;

      // Reset with everyone requesting, then continuous round-robin service
      vld = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         pa[32*i +: 32] = rand_fp();
         pb[32*i +: 32] = rand_fp();
      end
      hold_valid = 1'b1;
      rdy = 1'b1;
      applyReset(2);
      #1;
      checkOutput("t1_first_grant", 32'(req_ready), 32'h1);
      dut_grants.delete();
      grant_cyc.delete();
      repeat (15) applyStimulus();
      checkOutput("t3_grant_count", 32'(dut_grants.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++)
         if (i < dut_grants.size()) begin
            checkOutput("t3_order", 32'(dut_grants[i]), 32'(exp_order[i]));
            if (i > 0) checkOutput("t3_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
         end
      hold_valid = 1'b0;
      vld = '0;
      repeat (4) applyStimulus();

      // Single requester 2: 10000 + -8000
      setOperands(2, 32'h461C_4000, 32'hC5FA_0000);
      repeat (2) applyStimulus();
      checkOutput("t2_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t2_sum", rsp_sum, 32'h44FA_0000);
      checkOutput("t2_id", 32'(rsp_id), 32'd2);
      repeat (2) applyStimulus();

      // Held result under back-pressure, with another requester waiting
      rdy = 1'b0;
      setOperands(1, 32'hC5FA_0000, 32'h45FA_0000);
      applyStimulus();
      setOperands(3, rand_fp(), rand_fp());
      applyStimulus();
      repeat (5) begin
         checkOutput("t4_sum", rsp_sum, 32'h0000_0000);
         checkOutput("t4_id", 32'(rsp_id), 32'd1);
         checkOutput("t4_ready", 32'(req_ready), 32'd0);
         checkOutput("t4_busy", 32'(busy), 32'd1);
         applyStimulus();
      end
      rdy = 1'b1;
      repeat (6) applyStimulus();

      // Infinity and NaN operands
      setOperands(0, 32'h7F80_0000, 32'h3F80_0000);
      repeat (2) applyStimulus();
      checkOutput("t5_inf_sum", rsp_sum, 32'h7F80_0000);
      repeat (2) applyStimulus();
      setOperands(0, 32'h7F80_0001, 32'h3F80_0000);
      repeat (2) applyStimulus();
      checkOutput("t5_nan_sum", 32'((rsp_sum[30:23] == 8'hFF) && (rsp_sum[22:0] != 0)), 32'd1);
      repeat (2) applyStimulus();

      // Reset while a pair is in CALC: nothing comes out, requester 0 wins afterwards
      setOperands(2, rand_fp(), rand_fp());
      applyStimulus();
      setOperands(0, rand_fp(), rand_fp());
      setOperands(1, rand_fp(), rand_fp());
      applyReset(1);
      #1;
      checkOutput("t6_grant", 32'(req_ready), 32'h1);
      checkOutput("t6_no_rsp", 32'(rsp_valid), 32'd0);
      repeat (10) applyStimulus();

      // Random traffic with random back-pressure and requesters that withdraw
      repeat (400) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld[i] && $urandom_range(0, 2) == 0) setOperands(i, rand_fp(), rand_fp());
            else if (vld[i] && $urandom_range(0, 15) == 0) vld[i] = 1'b0;
         end
         rdy = ($urandom_range(0, 3) != 0);
         applyStimulus();
      end
      vld = '0;
      rdy = 1'b1;
      repeat (5) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
